// File: rtl/button_debounce_events.sv
// Debounce and event extraction for active-low push buttons: synchronizes nbtn,
// filters bounce on a shared sample tick, and emits press/release/long/repeat pulses.
module button_debounce_events #(
  parameter int NUM_BTN      = 8,
  parameter int TICK_DIV     = 8000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] nbtn,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] pressed;
  logic [TW-1:0]      tick_cnt;

  logic [DW-1:0] deb_cnt   [NUM_BTN];
  logic [DW-1:0] deb_cnt_d [NUM_BTN];
  logic [HW-1:0] hold_cnt  [NUM_BTN];
  logic [HW-1:0] hold_cnt_d[NUM_BTN];
  logic [RW-1:0] rep_cnt   [NUM_BTN];
  logic [RW-1:0] rep_cnt_d [NUM_BTN];

  logic [NUM_BTN-1:0] state_d, press_d, release_d, long_d, repeat_d;

  assign pressed = ~sync2;

  // Per-button next state; everything holds except in tick cycles, and pulses default low.
  always_comb begin
    deb_cnt_d  = deb_cnt;
    hold_cnt_d = hold_cnt;
    rep_cnt_d  = rep_cnt;
    state_d    = btn_state;
    press_d    = '0;
    release_d  = '0;
    long_d     = '0;
    repeat_d   = '0;
    if (tick) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pressed[i] == btn_state[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt_d[i] = '0;
          state_d[i]   = ~btn_state[i];
          press_d[i]   = pressed[i];
          release_d[i] = ~pressed[i];
        end else begin
          deb_cnt_d[i] = deb_cnt[i] + DW'(1);
        end

        // An accepted edge in either direction restarts hold timing and suppresses repeats.
        if (press_d[i] || release_d[i] || !btn_state[i]) begin
          hold_cnt_d[i] = '0;
          rep_cnt_d[i]  = '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt_d[i] = hold_cnt[i] + HW'(1);
          if (hold_cnt[i] == HOLD_LAST) begin
            long_d[i]    = 1'b1;
            rep_cnt_d[i] = '0;
          end
        end else if (rep_cnt[i] == REP_LAST) begin
          repeat_d[i]  = 1'b1;
          rep_cnt_d[i] = '0;
        end else begin
          rep_cnt_d[i] = rep_cnt[i] + RW'(1);
        end
      end
    end
  end

  // Synchronizers reset to released so a button held through reset reads as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      tick_cnt    <= '0;
      tick        <= 1'b0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end
    end else begin
      sync1       <= nbtn;
      sync2       <= sync1;
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      tick        <= (tick_cnt == TICK_LAST);
      btn_state   <= state_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
      btn_repeat  <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt[i]  <= deb_cnt_d[i];
        hold_cnt[i] <= hold_cnt_d[i];
        rep_cnt[i]  <= rep_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_events.sv
// Directed bench for button_debounce_events with a short time base
// (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=4).
module tb_button_debounce_events;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] nbtn;
  logic [7:0] btn_state, btn_press, btn_release, btn_long, btn_repeat;
  logic       tick;

  int checks = 0;
  int errors = 0;

  int press_cnt[8], release_cnt[8], long_cnt[8], repeat_cnt[8];
  int release_all = 0;

  button_debounce_events #(
    .NUM_BTN(8), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .nbtn(nbtn),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat), .tick(tick)
  );

  always #5 clk = ~clk;

  // Pulse tallies taken 1 time unit after each active edge.
  initial begin
    for (int i = 0; i < 8; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0; repeat_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        press_cnt[i]   += int'(btn_press[i]);
        release_cnt[i] += int'(btn_release[i]);
        long_cnt[i]    += int'(btn_long[i]);
        repeat_cnt[i]  += int'(btn_repeat[i]);
      end
      release_all += $countones(btn_release);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits up to budget negedges for any masked bit of the selected event vector; -1 on timeout.
  task automatic wait_event(input int sel, input logic [7:0] mask, input int budget, output int cycles);
    logic [7:0] vec;
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      case (sel)
        0:       vec = btn_press;
        1:       vec = btn_release;
        2:       vec = btn_long;
        default: vec = btn_repeat;
      endcase
      if ((vec & mask) != 8'h00) begin
        cycles = c;
        break;
      end
    end
  endtask

  int lat;
  int base_p, base_r, base_l, base_rep;

  initial begin
    rst  = 1'b1;
    nbtn = 8'h00;

    // Reset with every button held
    step(5);
    check_output("rst_state", btn_state, 8'h00);
    check_output("rst_press", btn_press, 8'h00);
    check_output("rst_release", btn_release, 8'h00);
    check_output("rst_long", btn_long, 8'h00);
    check_output("rst_repeat", btn_repeat, 8'h00);
    check_output("rst_tick", tick, 0);
    rst = 1'b0;
    wait_event(0, 8'hFF, 40, lat);
    check_output("held_press_lat", lat, 13);
    check_output("held_press_vec", btn_press, 8'hFF);
    check_output("held_state", btn_state, 8'hFF);
    step(1);
    check_output("held_press_pulse", btn_press, 8'h00);
    step(5);
    check_output("held_no_release", release_all, 0);
    nbtn = 8'hFF;
    wait_event(1, 8'hFF, 40, lat);
    check_output("all_release_vec", btn_release, 8'hFF);
    step(5);

    // Clean press and release on button 0
    base_p = press_cnt[0];
    base_r = release_cnt[0];
    nbtn[0] = 1'b0;
    wait_event(0, 8'h01, 30, lat);
    check_output("press0_lat", (lat >= 11 && lat <= 15), 1);
    check_output("press0_vec", btn_press, 8'h01);
    check_output("press0_state", btn_state, 8'h01);
    step(1);
    check_output("press0_pulse", btn_press, 8'h00);
    nbtn[0] = 1'b1;
    wait_event(1, 8'h01, 30, lat);
    check_output("release0_lat", (lat >= 11 && lat <= 15), 1);
    check_output("release0_vec", btn_release, 8'h01);
    check_output("release0_state", btn_state, 8'h00);
    step(3);
    check_output("press0_count", press_cnt[0] - base_p, 1);
    check_output("release0_count", release_cnt[0] - base_r, 1);

    // Bounce rejection on button 3
    base_p = press_cnt[3];
    base_r = release_cnt[3];
    nbtn[3] = 1'b0;
    step(8);
    nbtn[3] = 1'b1;
    step(20);
    check_output("bounce3_state", btn_state[3], 0);
    for (int k = 0; k < 10; k++) begin
      nbtn[3] = ~nbtn[3];
      step(4);
    end
    step(20);
    check_output("bounce3_state_alt", btn_state[3], 0);
    check_output("bounce3_press", press_cnt[3] - base_p, 0);
    check_output("bounce3_release", release_cnt[3] - base_r, 0);

    // Long press and auto-repeat on button 5
    base_p   = press_cnt[5];
    base_r   = release_cnt[5];
    base_l   = long_cnt[5];
    base_rep = repeat_cnt[5];
    nbtn[5] = 1'b0;
    wait_event(0, 8'h20, 30, lat);
    check_output("press5_vec", btn_press, 8'h20);
    wait_event(2, 8'h20, 60, lat);
    check_output("long5_lat", lat, 32);
    wait_event(3, 8'h20, 30, lat);
    check_output("repeat5_a", lat, 16);
    wait_event(3, 8'h20, 30, lat);
    check_output("repeat5_b", lat, 16);
    wait_event(3, 8'h20, 30, lat);
    check_output("repeat5_c", lat, 16);
    nbtn[5] = 1'b1;
    wait_event(1, 8'h20, 30, lat);
    check_output("release5_vec", btn_release, 8'h20);
    step(40);
    check_output("press5_count", press_cnt[5] - base_p, 1);
    check_output("release5_count", release_cnt[5] - base_r, 1);
    check_output("long5_count", long_cnt[5] - base_l, 1);
    check_output("repeat5_count", repeat_cnt[5] - base_rep, 3);

    // Simultaneous buttons 1 and 2
    nbtn[2:1] = 2'b00;
    wait_event(0, 8'h06, 30, lat);
    check_output("press12_vec", btn_press, 8'h06);
    wait_event(2, 8'h06, 60, lat);
    check_output("long12_lat", lat, 32);
    check_output("long12_vec", btn_long, 8'h06);
    nbtn[2:1] = 2'b11;
    wait_event(1, 8'h06, 30, lat);
    check_output("release12_vec", btn_release, 8'h06);
    step(10);

    // Reset while button 4 is held
    base_p = press_cnt[4];
    base_r = release_cnt[4];
    base_l = long_cnt[4];
    nbtn[4] = 1'b0;
    wait_event(0, 8'h10, 30, lat);
    check_output("press4_vec", btn_press, 8'h10);
    step(20);
    rst = 1'b1;
    step(1);
    check_output("midrst_state", btn_state, 8'h00);
    check_output("midrst_press", btn_press, 8'h00);
    check_output("midrst_long", btn_long, 8'h00);
    check_output("midrst_repeat", btn_repeat, 8'h00);
    check_output("midrst_tick", tick, 0);
    step(1);
    rst = 1'b0;
    wait_event(0, 8'h10, 30, lat);
    check_output("press4_again_lat", lat, 13);
    wait_event(2, 8'h10, 60, lat);
    check_output("long4_lat", lat, 32);
    nbtn[4] = 1'b1;
    step(20);
    check_output("press4_count", press_cnt[4] - base_p, 2);
    check_output("release4_count", release_cnt[4] - base_r, 1);
    check_output("long4_count", long_cnt[4] - base_l, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
